// File: rtl/soc_loader.sv
// HPS ioctl word download to SoC byte-wide ROM upload bus, with a small word FIFO
// and a SoC reset hold that outlasts the download by a fixed number of cycles.
module soc_loader #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int RESET_HOLD = 16
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic [7:0]            ioctl_index,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [15:0]           ioctl_dout,
  output logic                  ioctl_wait,
  output logic [ADDR_WIDTH-1:0] dn_addr,
  output logic [7:0]            dn_data,
  output logic [7:0]            dn_index,
  output logic                  dn_wr,
  output logic                  hold_reset,
  output logic                  overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

  logic [7:0]            r_q_idx  [DEPTH];
  logic [ADDR_WIDTH-1:0] r_q_addr [DEPTH];
  logic [15:0]           r_q_data [DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_hi_addr;
  logic [7:0]            r_hi_data;
  logic                  r_dn_wr;
  logic [ADDR_WIDTH-1:0] r_dn_addr;
  logic [7:0]            r_dn_data;
  logic [7:0]            r_dn_index;

  logic                  r_wait;
  logic                  r_overflow;
  logic [7:0]            r_hold_cnt;
  logic                  r_hold;

  logic                  w_in_range;
  logic                  w_empty, w_full;
  logic                  w_wr_ok, w_pop, w_push, w_drop;
  logic [CW-1:0]         w_count_nxt;
  logic                  w_busy;
  logic [7:0]            w_head_idx;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [15:0]           w_head_data;

  assign w_in_range  = (ioctl_addr[24:ADDR_WIDTH] == '0);
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_wr_ok     = ioctl_wr & w_in_range;
  // Pop is decided by the drain FSM alone, so a full FIFO can still accept a
  // word in the same cycle the FSM takes the head.
  assign w_pop       = ~w_empty & ((r_state == S_IDLE) | (r_state == S_HI));
  assign w_push      = w_wr_ok & (~w_full | w_pop);
  assign w_drop      = w_wr_ok & w_full & ~w_pop;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_busy      = ioctl_download | ~w_empty | (r_state != S_IDLE);

  assign w_head_idx  = r_q_idx[r_rptr];
  assign w_head_addr = r_q_addr[r_rptr];
  assign w_head_data = r_q_data[r_rptr];

  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_q_idx[r_wptr]  <= ioctl_index;
      r_q_addr[r_wptr] <= ioctl_addr[ADDR_WIDTH-1:0];
      r_q_data[r_wptr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_wait     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= w_count_nxt;
      r_wait  <= (w_count_nxt >= CW'(DEPTH - 1));
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hi_addr  <= '0;
      r_hi_data  <= '0;
      r_dn_wr    <= 1'b0;
      r_dn_addr  <= '0;
      r_dn_data  <= '0;
      r_dn_index <= '0;
    end else begin
      r_dn_wr <= 1'b0;
      case (r_state)
        S_LO: begin
          r_dn_wr   <= 1'b1;
          r_dn_addr <= r_hi_addr | ADDR_WIDTH'(1);
          r_dn_data <= r_hi_data;
          r_state   <= S_HI;
        end
        default: begin
          if (w_pop) begin
            r_dn_wr    <= 1'b1;
            r_dn_addr  <= w_head_addr & ~ADDR_WIDTH'(1);
            r_dn_data  <= w_head_data[7:0];
            r_dn_index <= w_head_idx;
            r_hi_addr  <= w_head_addr;
            r_hi_data  <= w_head_data[15:8];
            r_state    <= S_LO;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_hold_cnt <= 8'(RESET_HOLD);
      r_hold     <= 1'b1;
    end else if (w_busy) begin
      r_hold_cnt <= 8'(RESET_HOLD);
      r_hold     <= 1'b1;
    end else if (r_hold_cnt != '0) begin
      r_hold_cnt <= r_hold_cnt - 8'd1;
      r_hold     <= (r_hold_cnt != 8'd1);
    end else begin
      r_hold     <= 1'b0;
    end
  end

  assign ioctl_wait = r_wait;
  assign dn_wr      = r_dn_wr;
  assign dn_addr    = r_dn_addr;
  assign dn_data    = r_dn_data;
  assign dn_index   = r_dn_index;
  assign hold_reset = r_hold;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_soc_loader.sv
// Directed self-checking bench for soc_loader: latency, hold timing, backpressure,
// overflow, address range, index tagging and asynchronous reset mid-drain.
module tb_soc_loader;

  localparam int AW = 14;
  localparam int RH = 16;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [15:0]   ioctl_dout;
  logic          ioctl_wait;
  logic [AW-1:0] dn_addr;
  logic [7:0]    dn_data;
  logic [7:0]    dn_index;
  logic          dn_wr;
  logic          hold_reset;
  logic          overflow;

  soc_loader #(.DEPTH(4), .ADDR_WIDTH(AW), .RESET_HOLD(RH)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_index       (dn_index),
    .dn_wr          (dn_wr),
    .hold_reset     (hold_reset),
    .overflow       (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  typedef struct {
    int unsigned   c;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic [7:0]    x;
  } rec_t;
  rec_t q[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys)
    if (dn_wr === 1'b1) q.push_back('{c: cyc, a: dn_addr, d: dn_data, x: dn_index});

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    tick();
    tick();
    reset = 1'b0;
    q.delete();
  endtask

  task automatic wait_writes(input int unsigned n, input int unsigned budget);
    int unsigned b = 0;
    while (q.size() < n && b < budget) begin
      tick();
      b++;
    end
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned k;
    int unsigned budget;
    logic        w4, w5, seen_wait;
    logic [AW-1:0] ea [6];
    logic [7:0]    ed [6];
    logic [7:0]    ex [6];
    int unsigned   wl [9];

    // Reset values and post-reset hold.
    do_reset();
    check_eq("rst_dn_wr",    dn_wr, 0);
    check_eq("rst_dn_addr",  dn_addr, 0);
    check_eq("rst_dn_data",  dn_data, 0);
    check_eq("rst_dn_index", dn_index, 0);
    check_eq("rst_wait",     ioctl_wait, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_hold",     hold_reset, 1);
    repeat (RH - 1) tick();
    check_eq("rst_hold_last", hold_reset, 1);
    tick();
    check_eq("rst_hold_fall", hold_reset, 0);

    // Single word latency and hold after drain.
    tick();
    n = cyc;
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'h0010;
    ioctl_dout     = 16'hBEEF;
    tick();
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    while (cyc < n + 19) tick();
    check_eq("single_hold_n19", hold_reset, 1);
    tick();
    check_eq("single_hold_n20", hold_reset, 0);
    check_eq("single_count", q.size(), 2);
    check_eq("single_lo_cyc",  q[0].c, n + 2);
    check_eq("single_lo_addr", q[0].a, 14'h0010);
    check_eq("single_lo_data", q[0].d, 8'hEF);
    check_eq("single_lo_idx",  q[0].x, 8'h00);
    check_eq("single_hi_cyc",  q[1].c, n + 3);
    check_eq("single_hi_addr", q[1].a, 14'h0011);
    check_eq("single_hi_data", q[1].d, 8'hBE);

    // Out of range is discarded silently; top in-range word is accepted.
    q.delete();
    tick();
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h4000;
    ioctl_dout = 16'h1234;
    tick();
    ioctl_wr = 1'b0;
    repeat (8) tick();
    check_eq("oor_no_write", q.size(), 0);
    check_eq("oor_overflow", overflow, 0);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h3FFE;
    ioctl_dout = 16'hA55A;
    tick();
    ioctl_wr = 1'b0;
    repeat (6) tick();
    check_eq("edge_count",   q.size(), 2);
    check_eq("edge_lo_addr", q[0].a, 14'h3FFE);
    check_eq("edge_lo_data", q[0].d, 8'h5A);
    check_eq("edge_hi_addr", q[1].a, 14'h3FFF);
    check_eq("edge_hi_data", q[1].d, 8'hA5);

    // Index captured per word.
    q.delete();
    ea = '{14'h20, 14'h21, 14'h22, 14'h23, 14'h30, 14'h31};
    ed = '{8'h01, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    ex = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    tick();
    ioctl_download = 1'b1;
    ioctl_wr    = 1'b1;
    ioctl_index = 8'd0; ioctl_addr = 25'h20; ioctl_dout = 16'h2201;
    tick();
    ioctl_addr = 25'h22; ioctl_dout = 16'h4433;
    tick();
    ioctl_index = 8'd1; ioctl_addr = 25'h30; ioctl_dout = 16'h6655;
    tick();
    ioctl_wr    = 1'b0;
    ioctl_index = 8'd0;
    wait_writes(6, 40);
    check_eq("idx_count", q.size(), 6);
    for (int unsigned i = 0; i < 6; i++) begin
      check_eq($sformatf("idx_addr_%0d", i), q[i].a, ea[i]);
      check_eq($sformatf("idx_data_%0d", i), q[i].d, ed[i]);
      check_eq($sformatf("idx_tag_%0d", i),  q[i].x, ex[i]);
    end
    check_eq("idx_no_gap", q[5].c - q[0].c, 5);

    // Producer honours ioctl_wait: 64 words, no loss.
    q.delete();
    k = 0;
    budget = 0;
    seen_wait = 1'b0;
    while (k < 64 && budget < 1000) begin
      tick();
      budget++;
      if (ioctl_wait) begin
        seen_wait = 1'b1;
        ioctl_wr  = 1'b0;
      end else begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(2 * k);
        ioctl_dout = {8'(2 * k + 1), 8'(2 * k)};
        k++;
      end
    end
    tick();
    ioctl_wr = 1'b0;
    check_eq("bp_all_sent", k, 64);
    wait_writes(128, 400);
    ioctl_download = 1'b0;
    check_eq("bp_count", q.size(), 128);
    for (int unsigned i = 0; i < 128; i++) begin
      check_eq($sformatf("bp_addr_%0d", i), q[i].a, 14'(i));
      check_eq($sformatf("bp_data_%0d", i), q[i].d, 8'(i));
    end
    check_eq("bp_overflow", overflow, 0);
    check_eq("bp_wait_seen", seen_wait, 1);

    // Burst at one word per cycle ignoring wait: word 8 is dropped.
    do_reset();
    wl = '{0, 1, 2, 3, 4, 5, 6, 7, 9};
    tick();
    n = cyc;
    w4 = 1'b0;
    w5 = 1'b0;
    ioctl_download = 1'b1;
    for (int unsigned j = 0; j < 10; j++) begin
      if (j == 4) w4 = ioctl_wait;
      if (j == 5) w5 = ioctl_wait;
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(2 * j);
      ioctl_dout = {8'(2 * j + 1), 8'(2 * j)};
      tick();
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    wait_writes(18, 60);
    check_eq("burst_wait_n4", w4, 0);
    check_eq("burst_wait_n5", w5, 1);
    check_eq("burst_overflow", overflow, 1);
    check_eq("burst_count", q.size(), 18);
    check_eq("burst_first_cyc", q[0].c, n + 2);
    check_eq("burst_no_gap", q[17].c - q[0].c, 17);
    for (int unsigned j = 0; j < 18; j++) begin
      check_eq($sformatf("burst_addr_%0d", j), q[j].a, 14'(wl[j / 2] * 2 + j % 2));
      check_eq($sformatf("burst_data_%0d", j), q[j].d, 8'(wl[j / 2] * 2 + j % 2));
    end

    // Asynchronous reset while the high byte is on the bus.
    do_reset();
    tick();
    ioctl_download = 1'b1;
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h100; ioctl_dout = 16'h1111;
    tick();
    ioctl_addr = 25'h102; ioctl_dout = 16'h2222;
    tick();
    ioctl_addr = 25'h104; ioctl_dout = 16'h3333;
    tick();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    check_eq("mid_pre_wr",   dn_wr, 1);
    check_eq("mid_pre_addr", dn_addr, 14'h101);
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_wr",   dn_wr, 0);
    check_eq("mid_rst_hold", hold_reset, 1);
    check_eq("mid_rst_wait", ioctl_wait, 0);
    tick();
    reset = 1'b0;
    q.delete();
    repeat (RH - 1) tick();
    check_eq("mid_hold_last", hold_reset, 1);
    tick();
    check_eq("mid_hold_fall", hold_reset, 0);
    repeat (5) tick();
    check_eq("mid_fifo_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
